// File: rtl/if_prefetch_unit.sv
// Sequential instruction fetch into a DEPTH-entry prefetch FIFO; a word shows at decode one cycle after accept,
// and fetch stalls while the FIFO is full. Define IFU_MISALIGN_CHECK_EN to trap misaligned redirects.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif

module if_prefetch_unit #(
   parameter int              XLEN     = `XLEN,
   parameter int              ADDR_W   = `ADDR_W,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_en,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic              mem_ready,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [XLEN-1:0]   inst_out,
   output logic [XLEN-1:0]   inst_pc,
   output logic              inst_fault
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

`ifdef IFU_MISALIGN_CHECK_EN
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FAULT} state_t;
`else
   typedef enum logic [0:0] {ST_IDLE, ST_RUN} state_t;
`endif

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } entry_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   entry_t          mem_q [DEPTH];

   logic            wr_en;
   logic [PW-1:0]   wr_idx;
   entry_t          wr_data;
   logic            push;
   logic            pop;
`ifdef IFU_MISALIGN_CHECK_EN
   logic [DEPTH-1:0] fault_q;
   logic             wr_fault;
`endif

   assign mem_req    = (state_q == ST_RUN) && (count_q < CW'(DEPTH)) && !redirect_valid;
   assign mem_addr   = ADDR_W'(fetch_pc_q);
   assign inst_valid = (count_q != '0);
   assign inst_out   = inst_valid ? mem_q[rd_ptr_q].inst : '0;
   assign inst_pc    = inst_valid ? mem_q[rd_ptr_q].pc : '0;
`ifdef IFU_MISALIGN_CHECK_EN
   assign inst_fault = inst_valid & fault_q[rd_ptr_q];
`else
   assign inst_fault = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      wr_en      = 1'b0;
      wr_idx     = wr_ptr_q;
      wr_data    = '{pc: fetch_pc_q, inst: mem_rdata};
`ifdef IFU_MISALIGN_CHECK_EN
      wr_fault   = 1'b0;
`endif
      push       = mem_req && mem_ready;
      pop        = inst_valid && inst_ready && !redirect_valid;

      if (redirect_valid) begin
         // Redirect overrides everything: flush, and neither push nor pop this cycle.
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         state_d  = fetch_en ? ST_RUN : ST_IDLE;
`ifdef IFU_MISALIGN_CHECK_EN
         fetch_pc_d = redirect_pc;
         if (redirect_pc[1:0] != 2'b00) begin
            wr_en    = 1'b1;
            wr_idx   = '0;
            wr_data  = '{pc: redirect_pc, inst: XLEN'(32'h0000_0013)};
            wr_fault = 1'b1;
            count_d  = CW'(1);
            wr_ptr_d = PW'(1);
            state_d  = ST_FAULT;
         end
`else
         fetch_pc_d = redirect_pc & ~XLEN'(3);
`endif
      end else begin
         case (state_q)
            ST_IDLE: if (fetch_en)  state_d = ST_RUN;
            ST_RUN:  if (!fetch_en) state_d = ST_IDLE;
            default: state_d = state_q;
         endcase
         if (push) begin
            wr_en      = 1'b1;
            wr_ptr_d   = wr_ptr_q + PW'(1);
            fetch_pc_d = fetch_pc_q + XLEN'(4);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CW'(1);
         end else if (pop && !push) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_PC;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Storage needs no reset: entries are only visible while count is nonzero.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

`ifdef IFU_MISALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) begin
         fault_q[wr_idx] <= wr_fault;
      end
   end
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: fetch stream, backpressure, stalls, redirects and reset.
module tb_if_prefetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        inst_fault;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1234_5678;
   endfunction

   assign mem_rdata = model(mem_addr);

   if_prefetch_unit dut (
      .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
      .inst_pc(inst_pc), .inst_fault(inst_fault)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic flush_to(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      tick();
      redirect_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      mem_ready = 1'b0; inst_ready = 1'b0;
      tick(); tick();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got %b exp 0", inst_valid); end
      checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL reset_inst_out got %h exp 0", inst_out); end
      checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc got %h exp 0", inst_pc); end
      checks++; if (inst_fault !== 1'b0) begin errors++; $display("FAIL reset_inst_fault got %b exp 0", inst_fault); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_sequential();
      fetch_en = 1'b1; mem_ready = 1'b1; inst_ready = 1'b1;
      #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL seq_idle_req got %b exp 0", mem_req); end
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
         errors++; $display("FAIL seq_first_req got req=%b addr=%h exp req=1 addr=0", mem_req, mem_addr); end
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++; if (mem_addr !== 32'(4 * i)) begin
            errors++; $display("FAIL seq_addr got %h exp %h", mem_addr, 32'(4 * i)); end
         checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * (i - 1)) || inst_out !== model(32'(4 * (i - 1)))) begin
            errors++; $display("FAIL seq_head got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                               inst_valid, inst_pc, inst_out, 32'(4 * (i - 1)), model(32'(4 * (i - 1)))); end
      end
   endtask

   task automatic test_full_backpressure();
      int acc;
      inst_ready = 1'b0; mem_ready = 1'b1; fetch_en = 1'b1;
      flush_to(32'h0);
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         if (mem_req && mem_ready) acc++;
         tick();
      end
      checks++; if (acc != 4) begin errors++; $display("FAIL full_accepts got %0d exp 4", acc); end
      checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h10) begin
         errors++; $display("FAIL full_stall got req=%b addr=%h exp req=0 addr=10", mem_req, mem_addr); end
      inst_ready = 1'b1;
      #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_pop_req got %b exp 0", mem_req); end
      checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL full_pop0 got %h exp 0", inst_pc); end
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++; if (inst_pc !== 32'(4 * k) || inst_out !== model(32'(4 * k))) begin
            errors++; $display("FAIL full_pop_order got pc=%h inst=%h exp pc=%h", inst_pc, inst_out, 32'(4 * k)); end
      end
   endtask

   task automatic test_mem_stall();
      inst_ready = 1'b1; mem_ready = 1'b1;
      flush_to(32'h0);
      tick(); tick();
      mem_ready = 1'b0;
      #1;
      checks++; if (mem_addr !== 32'h8 || inst_valid !== 1'b1 || inst_pc !== 32'h4) begin
         errors++; $display("FAIL stall_start got addr=%h v=%b pc=%h exp addr=8 v=1 pc=4", mem_addr, inst_valid, inst_pc); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (mem_addr !== 32'h8 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL stall_hold got addr=%h v=%b exp addr=8 v=0", mem_addr, inst_valid); end
      end
      mem_ready = 1'b1;
      #1;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL stall_resume_req got %b exp 1", mem_req); end
      tick();
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || mem_addr !== 32'hC) begin
         errors++; $display("FAIL stall_resume got v=%b pc=%h addr=%h exp v=1 pc=8 addr=c", inst_valid, inst_pc, mem_addr); end
   endtask

   task automatic test_redirect_flush();
      inst_ready = 1'b0; mem_ready = 1'b1;
      flush_to(32'h0);
      tick(); tick(); tick();
      checks++; if (inst_valid !== 1'b1 || mem_addr !== 32'hC || inst_pc !== 32'h0) begin
         errors++; $display("FAIL flush_fill got v=%b addr=%h pc=%h exp v=1 addr=c pc=0", inst_valid, mem_addr, inst_pc); end
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL flush_req_masked got %b exp 0", mem_req); end
      tick();
      redirect_valid = 1'b0;
      #1;
      checks++; if (inst_valid !== 1'b0 || mem_addr !== 32'h100 || mem_req !== 1'b1) begin
         errors++; $display("FAIL flush_after got v=%b addr=%h req=%b exp v=0 addr=100 req=1", inst_valid, mem_addr, mem_req); end
      inst_ready = 1'b1;
      tick();
      checks++; if (inst_pc !== 32'h100 || inst_out !== model(32'h100)) begin
         errors++; $display("FAIL flush_first got pc=%h inst=%h exp pc=100 inst=%h", inst_pc, inst_out, model(32'h100)); end
   endtask

   task automatic test_redirect_pop_wrap();
      inst_ready = 1'b0; mem_ready = 1'b1;
      flush_to(32'h0);
      tick(); tick();
      inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      #1;
      checks++; if (inst_valid !== 1'b0 || mem_addr !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wrap_redirect got v=%b addr=%h exp v=0 addr=fffffffc", inst_valid, mem_addr); end
      tick();
      checks++; if (inst_pc !== 32'hFFFF_FFFC || inst_out !== model(32'hFFFF_FFFC) || mem_addr !== 32'h0) begin
         errors++; $display("FAIL wrap_top got pc=%h inst=%h addr=%h exp pc=fffffffc addr=0", inst_pc, inst_out, mem_addr); end
      tick();
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
         errors++; $display("FAIL wrap_zero got v=%b pc=%h exp v=1 pc=0", inst_valid, inst_pc); end
   endtask

   task automatic test_misalign();
      inst_ready = 1'b0; mem_ready = 1'b1; fetch_en = 1'b1;
      flush_to(32'h102);
`ifdef IFU_MISALIGN_CHECK_EN
      checks++; if (inst_fault !== 1'b1 || inst_pc !== 32'h102 || inst_out !== 32'h13 || mem_req !== 1'b0) begin
         errors++; $display("FAIL misalign_trap got f=%b pc=%h inst=%h req=%b exp f=1 pc=102 inst=13 req=0",
                            inst_fault, inst_pc, inst_out, mem_req); end
      tick(); tick();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL misalign_hold got %b exp 0", mem_req); end
      flush_to(32'h0);
      checks++; if (mem_req !== 1'b1 || inst_valid !== 1'b0) begin
         errors++; $display("FAIL misalign_exit got req=%b v=%b exp req=1 v=0", mem_req, inst_valid); end
`else
      checks++; if (mem_addr !== 32'h100 || mem_req !== 1'b1 || inst_fault !== 1'b0) begin
         errors++; $display("FAIL misalign_align got addr=%h req=%b f=%b exp addr=100 req=1 f=0", mem_addr, mem_req, inst_fault); end
      tick();
      checks++; if (inst_pc !== 32'h100 || inst_fault !== 1'b0) begin
         errors++; $display("FAIL misalign_head got pc=%h f=%b exp pc=100 f=0", inst_pc, inst_fault); end
`endif
   endtask

   task automatic test_fetch_disabled();
      fetch_en = 1'b0; inst_ready = 1'b1; mem_ready = 1'b1;
      flush_to(32'h40);
      checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h40 || inst_valid !== 1'b0) begin
         errors++; $display("FAIL idle_redirect got req=%b addr=%h v=%b exp req=0 addr=40 v=0", mem_req, mem_addr, inst_valid); end
      tick(); tick(); tick();
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL empty_underflow got %b exp 0", inst_valid); end
      fetch_en = 1'b1;
      #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL idle_to_run_req got %b exp 0", mem_req); end
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
         errors++; $display("FAIL run_req got req=%b addr=%h exp req=1 addr=40", mem_req, mem_addr); end
      tick();
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin
         errors++; $display("FAIL run_head got v=%b pc=%h exp v=1 pc=40", inst_valid, inst_pc); end
   endtask

   task automatic test_reset_mid();
      fetch_en = 1'b1; mem_ready = 1'b1; inst_ready = 1'b0;
      tick(); tick();
      rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
      tick();
      redirect_valid = 1'b0;
      #1;
      checks++; if (mem_addr !== 32'h0 || inst_valid !== 1'b0 || mem_req !== 1'b0) begin
         errors++; $display("FAIL reset_mid got addr=%h v=%b req=%b exp addr=0 v=0 req=0", mem_addr, inst_valid, mem_req); end
      rst_n = 1'b1; fetch_en = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_full_backpressure();
      test_mem_stall();
      test_redirect_flush();
      test_redirect_pop_wrap();
      test_misalign();
      test_fetch_disabled();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
